// File: rtl/data_mem_access_unit.sv
// Memory-stage load/store unit: turns a decoded MemRead/MemWrite into a ready-handshaked
// word-bus transaction, stalls the pipeline until it completes and returns the extended load data.
module data_mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic              req_q, we_q, done_q, fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q;

    logic              op_present, dir_ok, f3_ok, align_ok, legal;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;

    // Lane select plus sign/zero extension of the returned bus word.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        op_present = MemRead | MemWrite;
        dir_ok     = MemRead ^ MemWrite;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = MemRead;
            default:                f3_ok = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = dir_ok & f3_ok & align_ok;
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata;
            end
        endcase
    end

    assign stall = ((state_q == IDLE) && op_present && legal) || (state_q == REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    if (op_present && legal) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWrite;
                        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        f3_q    <= funct3;
                        lane_q  <= addr[1:0];
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end else if (op_present) begin
                        // Illegal access never reaches the bus; it just reports and lets the pipe move.
                        rdata_q <= '0;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        req_q   <= 1'b0;
                        rdata_q <= we_q ? 32'b0 : load_extract(f3_q, lane_q, bus_rdata);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Op inputs still show the finished instruction here; they are ignored.
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: randomized loads/stores with a behavioural
// reference model, a bus responder with per-transaction latency, and a decoupled output monitor.
module tb_data_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, done, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    data_mem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .done(done), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    typedef struct {
        bit          legal;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic [31:0] exp_rdata;
        bit          exp_fault;
        int          nreq;
        bit          no_done;
    } txn_t;

    txn_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   reqcnt = 0;
    bit   rq_prev = 1'b0;
    bit   rprev = 1'b0;
    int   k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: access rules applied with plain arithmetic on the byte address.
    function automatic txn_t model(input bit mr, input bit mw, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input int lat, input logic [31:0] rd);
        txn_t   t;
        int     size;
        bit     f3ok;
        longint v;
        size = int'(f3) % 4;
        f3ok = mw ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        t.legal = (mr != mw) && f3ok && ((a % (32'd1 << size)) == 0);
        t.we    = mw;
        t.addr  = a - (a % 4);
        t.be    = (size == 0) ? 4'(1 << (a % 4)) : (size == 1) ? 4'(3 << (a % 4)) : 4'hF;
        t.wd    = (size == 0) ? (wd & 32'hFF) * 32'h01010101 :
                  (size == 1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        t.lat   = lat;
        t.rd    = rd;
        t.no_done = 1'b0;
        if (!t.legal) begin
            t.exp_fault = 1'b1; t.exp_rdata = '0; t.nreq = 0;
        end else if (lat >= TO) begin
            t.exp_fault = 1'b1; t.exp_rdata = '0; t.nreq = TO;
        end else begin
            t.exp_fault = 1'b0; t.nreq = lat + 1;
            v = longint'(rd >> (8 * (a % 4)));
            case (f3)
                3'd0: begin v = v & 255;   if (v >= 128)   v = v - 256;   end
                3'd1: begin v = v & 65535; if (v >= 32768) v = v - 65536; end
                3'd4: v = v & 255;
                3'd5: v = v & 65535;
                default: v = longint'(rd);
            endcase
            t.exp_rdata = mw ? 32'd0 : 32'(v);
        end
        return t;
    endfunction

    // Present one instruction; the pipeline moves on after any edge that saw stall low.
    task automatic issue(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rd);
        txn_t t;
        int   held, exph;
        bit   s;
        t = model(mr, mw, f3, a, wd, lat, rd);
        MemRead = mr; MemWrite = mw; funct3 = f3; addr = a; wdata = wd;
        if (mr | mw) sb.push_back(t);
        exph = ((mr | mw) && t.legal) ? 2 + t.nreq : 1;
        held = 0;
        do begin
            @(negedge clk); s = stall;
            @(posedge clk); #1;
            held++;
        end while (s && held < 40);
        chk("stall_cycles", held, exph);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, bus_req, 0);
        chk({tag, "_we"}, bus_we, 0);
        chk({tag, "_addr"}, bus_addr, 0);
        chk({tag, "_be"}, bus_be, 0);
        chk({tag, "_wdata"}, bus_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    // Bus responder: asserts ready after the latency chosen for the transaction in flight.
    always @(posedge clk) begin
        #1;
        if (bus_req && sb.size() > 0) begin
            if (!rprev) k = 0; else k++;
            bus_ready = (k == sb[0].lat);
            bus_rdata = sb[0].rd;
        end else begin
            bus_ready = 1'b0;
            bus_rdata = $urandom;
        end
        rprev = bus_req;
    end

    // Monitor: compares bus fields while requesting and pops the scoreboard on each done.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (reset) begin
                reqcnt = 0;
            end else begin
                if (bus_req) begin
                    if (sb.size() == 0 || !sb[0].legal) begin
                        flag("bus_req_unexpected");
                    end else begin
                        chk("bus_we", bus_we, sb[0].we);
                        chk("bus_addr", bus_addr, sb[0].addr);
                        chk("bus_be", bus_be, sb[0].be);
                        chk("bus_wdata", bus_wdata, sb[0].wd);
                        reqcnt = rq_prev ? reqcnt + 1 : 1;
                    end
                end
                if (fault && !done) flag("fault_without_done");
                if (done) begin
                    if (sb.size() == 0) begin
                        flag("done_spurious");
                    end else begin
                        t = sb.pop_front();
                        if (t.no_done) begin
                            flag("done_after_reset");
                        end else begin
                            chk("rdata", rdata, t.exp_rdata);
                            chk("fault", fault, t.exp_fault);
                            chk("req_cycles", reqcnt, t.nreq);
                        end
                    end
                    reqcnt = 0;
                end
            end
            rq_prev = bus_req;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        txn_t t;
        int   r;
        bit   mr, mw;
        logic [2:0]  f3;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        issue(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        issue(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFFFF);
        issue(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FFFFFF);
        issue(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'h0);
        issue(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        issue(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0);
        issue(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
        issue(1, 0, 3'b010, 32'h300, 32'h0, 10, 32'h0);
        issue(1, 0, 3'b001, 32'h302, 32'h0, 3, 32'h8001FFFF);

        // Reset in the second REQ cycle abandons the access silently.
        t = model(1, 0, 3'b010, 32'h80, 32'h0, 10, 32'h12345678);
        t.no_done = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h80;
        sb.push_back(t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; MemRead = 1'b0;
        @(posedge clk); #1;
        check_all_zero("mid_req_reset");
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("sb_after_reset", sb.size(), 1);
        sb.delete();
        issue(0, 1, 3'b010, 32'h40, 32'h55, 0, 32'h0);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 19);
            mr = (r >= 2 && r < 11) || r >= 18;
            mw = (r >= 11);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (mw) f3 = 3'($urandom_range(0, 2));
            else begin
                r = $urandom_range(0, 4);
                f3 = (r > 2) ? 3'(r + 1) : 3'(r);
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            issue(mr, mw, f3, a, $urandom, $urandom_range(0, 5), $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
